// File: rtl/fetch_pkg.sv
// Shared types and constants for the dual-issue fetch front end.
package fetch_pkg;

  localparam int unsigned ADDR_W      = 32;
  localparam int unsigned INSTR_W     = 32;
  localparam int unsigned FETCH_BYTES = 8;
  // Wide enough to count 0..4 in-flight requests
  localparam int unsigned OUTS_W      = 3;

  localparam logic [1:0] MASK_BOTH = 2'b11;
  localparam logic [1:0] MASK_HI   = 2'b10;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    STALL = 2'd2
  } fetch_state_e;

  // One in-flight request: pair address without the byte offset, plus the
  // flag telling whether only the upper lane of the pair is live.
  typedef struct packed {
    logic [ADDR_W-4:0] addr_hi;
    logic              first_lane;
  } req_entry_t;

  // Clear the byte offset inside an 8-byte instruction pair
  function automatic logic [ADDR_W-1:0] align_pair(input logic [ADDR_W-1:0] addr);
    return addr & ~ADDR_W'(FETCH_BYTES - 1);
  endfunction

endpackage

// File: rtl/fetch_req_queue.sv
// In-order queue of in-flight fetch requests; its occupancy is the
// outstanding-request counter of the fetch unit.
module fetch_req_queue
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  req_entry_t        push_data,
  input  logic              pop,
  output req_entry_t        head,
  output logic [OUTS_W-1:0] count
);

  localparam int unsigned      PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST  = PTR_W'(DEPTH - 1);

  req_entry_t       entries [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  // A pop on an empty queue is a stray response and is ignored
  assign do_pop  = pop & (count != '0);
  assign do_push = push & ((count < OUTS_W'(DEPTH)) | do_pop);
  assign head    = entries[rd_ptr];

  // Storage, pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        entries[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        entries[wr_ptr] <= push_data;
        wr_ptr          <= (wr_ptr == LAST) ? '0 : wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + PTR_W'(1);
      end
      count <= count + OUTS_W'(do_push) - OUTS_W'(do_pop);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Dual-issue instruction fetch front end: owns the PC, issues 64-bit pair
// requests, drops responses made stale by redirects and writes instruction
// pairs to the decode FIFO.
// Optional build macro FETCH_PERF_CNT_EN adds perf_pairs / perf_dropped.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stop_fetch,
  input  logic               jump,
  input  logic               jump_accept,
  input  logic [ADDR_W-1:0]  jump_addr,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [ADDR_W-1:0]  imem_req_addr,
  input  logic               imem_rsp_valid,
  input  logic [63:0]        imem_rsp_data,
  output logic               fetch_valid,
  output logic [ADDR_W-1:0]  fetch_pc,
  output logic [INSTR_W-1:0] fetch_instr1,
  output logic [INSTR_W-1:0] fetch_instr2,
  output logic [1:0]         fetch_mask
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]        perf_pairs,
  output logic [31:0]        perf_dropped
`endif
);

  fetch_state_e      state;
  fetch_state_e      state_nxt;
  logic [ADDR_W-1:0] pc;
  logic              first_lane;
  logic [OUTS_W-1:0] outstanding;
  logic [OUTS_W-1:0] outstanding_nxt;
  logic [OUTS_W-1:0] drop_cnt;
  logic              redirect;
  logic              req_fire;
  logic              rsp_take;
  logic              rsp_keep;
  req_entry_t        push_entry;
  req_entry_t        head;

  assign redirect = jump & jump_accept;

  // A request is held back during a redirect so the old PC never escapes
  assign imem_req_valid = (state == RUN) & ~stop_fetch &
                          (outstanding < OUTS_W'(MAX_OUTSTANDING)) & ~redirect;
  assign imem_req_addr  = pc;

  assign req_fire = imem_req_valid & imem_req_ready;
  assign rsp_take = imem_rsp_valid & (outstanding != '0);
  assign rsp_keep = rsp_take & ~redirect & (drop_cnt == '0);

  // In-flight count once this cycle's push and pop have both landed
  assign outstanding_nxt = outstanding + OUTS_W'(req_fire) - OUTS_W'(rsp_take);

  assign push_entry = '{addr_hi: pc[ADDR_W-1:3], first_lane: first_lane};

  fetch_req_queue #(
    .DEPTH(MAX_OUTSTANDING)
  ) u_req_queue (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (req_fire),
    .push_data(push_entry),
    .pop      (rsp_take),
    .head     (head),
    .count    (outstanding)
  );

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= BOOT;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next state; redirects never change the state
  always_comb begin
    state_nxt = state;
    case (state)
      BOOT:    state_nxt = RUN;
      RUN:     if (stop_fetch) state_nxt = STALL;
      STALL:   if (!stop_fetch) state_nxt = RUN;
      default: state_nxt = BOOT;
    endcase
  end

  // PC, half-pair flag and stale-response drop counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc         <= RESET_PC;
      first_lane <= 1'b0;
      drop_cnt   <= '0;
    end else begin
      if (redirect) begin
        pc         <= align_pair(jump_addr);
        first_lane <= jump_addr[2];
      end else if (req_fire) begin
        pc         <= pc + ADDR_W'(FETCH_BYTES);
        first_lane <= 1'b0;
      end
      if (redirect) begin
        drop_cnt <= outstanding_nxt;
      end else if (rsp_take && (drop_cnt != '0)) begin
        drop_cnt <= drop_cnt - OUTS_W'(1);
      end
    end
  end

  // Registered write port towards the instruction FIFO
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_valid  <= 1'b0;
      fetch_pc     <= '0;
      fetch_instr1 <= '0;
      fetch_instr2 <= '0;
      fetch_mask   <= '0;
    end else begin
      fetch_valid <= rsp_keep;
      if (rsp_keep) begin
        fetch_pc     <= {head.addr_hi, 3'b000};
        fetch_instr1 <= imem_rsp_data[INSTR_W-1:0];
        fetch_instr2 <= imem_rsp_data[2*INSTR_W-1:INSTR_W];
        fetch_mask   <= head.first_lane ? MASK_HI : MASK_BOTH;
      end
    end
  end

`ifdef FETCH_PERF_CNT_EN
  // Delivered-pair and discarded-response counters, wrapping at 2^32
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_pairs   <= '0;
      perf_dropped <= '0;
    end else begin
      if (fetch_valid) begin
        perf_pairs <= perf_pairs + 32'd1;
      end
      if (rsp_take && !rsp_keep) begin
        perf_dropped <= perf_dropped + 32'd1;
      end
    end
  end
`endif

endmodule
